conv2d_mac_engine: RTL
======================

Name: conv2d_mac_engine

Overview:
- Parametrised 2D convolution engine: slides a KER x KER x CH kernel over a CH-channel IMG x IMG signed image with configurable stride.
- Produces a saturated, right-shifted output map. Results are streamed per pixel and also held in a full output array.
- Uses one time-multiplexed multiplier, with a start/busy/done handshake.
- Sits between the image buffer and the activation/pooling stage of the CNN pipeline.

Parameters:
- IMG, 7, input image side length.
- KER, 3, kernel side length (KER <= IMG).
- CH, 1, input channel count; the result is summed over all channels.
- STRIDE, 1, window step in rows and columns. (IMG-KER)%STRIDE must be 0, otherwise $error at elaboration.
- WIDTH_BIT, 8, signed width of image, kernel and output samples.
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation (0..2*WIDTH_BIT-1).
- Localparams: OUT = (IMG-KER)/STRIDE+1; N = KER*KER*CH; ACC_W = 2*WIDTH_BIT + $clog2(N) + 1.

Ports:
- clock  in  1  rising-edge clock.
- nreset  in  1  asynchronous, active-low reset.
- start  in  1  request a full-image convolution; sampled only in IDLE.
- inpMatrixI  in  signed [WIDTH_BIT-1:0] [CH-1:0][IMG-1:0][IMG-1:0]  image; must be held stable while busy=1.
- kernel  in  signed [WIDTH_BIT-1:0] [CH-1:0][KER-1:0][KER-1:0]  weights; must be held stable while busy=1.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse when the whole map is complete.
- out_valid  out  1  one-cycle pulse per output pixel.
- out_row  out  $clog2(OUT)+1  output row index of out_data.
- out_col  out  $clog2(OUT)+1  output column index of out_data.
- out_data  out  signed [WIDTH_BIT-1:0]  pixel result.
- convOut  out  signed [WIDTH_BIT-1:0] [OUT-1:0][OUT-1:0]  full result map.

Behaviour:
- Reset: async, nreset low. State=IDLE. busy, done, out_valid = 0. out_row, out_col, out_data = 0. All convOut entries = 0. Accumulator and all counters = 0.
- FSM states: IDLE, LOAD, MAC, WRITE, DONE.
- IDLE: if start=1, go to LOAD. Output row/col counters r=c=0.
- LOAD (1 cycle): clear the accumulator. Window origin = (r*STRIDE, c*STRIDE). Tap counter = 0.
- MAC (N cycles): each cycle, acc += sign-extended(img[ch][r*STRIDE+kr][c*STRIDE+kc] * kernel[ch][kr][kc]).
  - Tap order: kc fastest, then kr, then ch.
  - Product width is 2*WIDTH_BIT; accumulation is full ACC_W, so overflow is impossible.
- WRITE (1 cycle):
  - res = acc >>> SHIFT (arithmetic).
  - Saturate res to [-2^(WIDTH_BIT-1), 2^(WIDTH_BIT-1)-1].
  - Register out_data=res, out_row=r, out_col=c, convOut[r][c]=res. out_valid=1 for exactly the following cycle.
  - Then advance c. On wrap (c=OUT-1), set c=0 and advance r.
  - If the pixel just written was (OUT-1, OUT-1), go to DONE; otherwise go to LOAD.
- DONE (1 cycle): done=1, busy=0, then IDLE.
- Timing:
  - Start accepted at edge E. First out_valid is high in cycle E+N+2.
  - Consecutive out_valid pulses are N+2 cycles apart.
  - done is high in cycle E + OUT*OUT*(N+2) + 1.
- start is ignored while busy or in DONE. No queuing.
- convOut persists after done until overwritten by the next run; it is not cleared at start.
- out_row, out_col and out_data hold their last values between pulses.
- Reset mid-run: immediately returns to IDLE with all outputs cleared. A partial map is discarded.
- Back-to-back: start high in the cycle after done is accepted normally.

Test Plan:
1. IMG=7, KER=3, CH=1, STRIDE=1, SHIFT=0. Image all 1, kernel all 1, pulse start -> 25 out_valid pulses, each out_data=9, raster order (0,0)..(4,4). done in cycle 276 after the start edge. All convOut entries = 9.
2. Image all 127, kernel all 127 (sum 145161) -> every out_data=127 (positive saturation). Image all -128, kernel all 127 -> every out_data=-128.
3. STRIDE=2, IMG=7, KER=3. Image[r][c]=r, kernel all 1 -> OUT=3. Row k outputs = 3*(2k)+3*(2k+1)+3*(2k+2) = 18k+9, giving 9, 27, 45 per row. 9 pulses total.
4. CH=2, SHIFT=2. Channel 0 image all 2, channel 1 image all 3, kernel all 1 -> acc=45, out_data=11. N=18, so pulses are 20 cycles apart.
5. Drop nreset during the 10th MAC cycle of pixel (2,1) -> busy, out_valid, done and all convOut go to 0 asynchronously. Re-start after release gives the same results as scenario 1.
6. Pulse start again while busy, and in the done cycle -> ignored; pixel count and done timing unchanged. Start in the cycle after done -> a second run completes with identical output.

Source files
------------

// File: rtl/conv2d_mac_engine.sv
// 2D convolution engine: slides a KER x KER x CH kernel over a CH x IMG x IMG
// signed image using a single time-multiplexed multiplier. Each output pixel is
// accumulated at full precision, arithmetically shifted, saturated, streamed
// out with a one-cycle valid pulse and stored in the full result map.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; output row/col counters held at 0
//   S_LOAD  | clear accumulator, latch window origin, reset tap counters
//   S_MAC   | one kernel tap per cycle (kc fastest, then kr, then ch)
//   S_WRITE | shift/saturate, register pixel outputs, advance row/col
//   S_DONE  | whole map written; done pulses in the following cycle
module conv2d_mac_engine #(
    parameter int IMG       = 7,
    parameter int KER       = 3,
    parameter int CH        = 1,
    parameter int STRIDE    = 1,
    parameter int WIDTH_BIT = 8,
    parameter int SHIFT     = 0,
    localparam int OUT      = (IMG - KER) / STRIDE + 1,
    localparam int RC_W     = $clog2(OUT) + 1
) (
    input  logic                                          clock,
    input  logic                                          nreset,
    input  logic                                          start,
    input  logic [CH-1:0][IMG-1:0][IMG-1:0][WIDTH_BIT-1:0] inpMatrixI,
    input  logic [CH-1:0][KER-1:0][KER-1:0][WIDTH_BIT-1:0] kernel,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          out_valid,
    output logic [RC_W-1:0]                               out_row,
    output logic [RC_W-1:0]                               out_col,
    output logic [WIDTH_BIT-1:0]                          out_data,
    output logic [OUT-1:0][OUT-1:0][WIDTH_BIT-1:0]         convOut
);

    localparam int N     = KER * KER * CH;
    localparam int ACC_W = 2 * WIDTH_BIT + $clog2(N) + 1;
    localparam int PW    = 2 * WIDTH_BIT;
    localparam int KR_W  = $clog2(KER) + 1;
    localparam int CH_W  = $clog2(CH) + 1;
    localparam int IX_W  = $clog2(IMG) + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (WIDTH_BIT - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    generate
        if ((IMG - KER) % STRIDE != 0) begin : g_bad_stride
            $error("conv2d_mac_engine: (IMG-KER) is not a multiple of STRIDE");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WRITE, S_DONE} state_t;

    state_t                                  r_state;
    state_t                                  w_next;
    logic [RC_W-1:0]                         r_row;
    logic [RC_W-1:0]                         r_col;
    logic [IX_W-1:0]                         r_org_r;
    logic [IX_W-1:0]                         r_org_c;
    logic [KR_W-1:0]                         r_kr;
    logic [KR_W-1:0]                         r_kc;
    logic [CH_W-1:0]                         r_ch;
    logic signed [ACC_W-1:0]                 r_acc;
    logic                                    r_valid;
    logic                                    r_done;
    logic [RC_W-1:0]                         r_out_row;
    logic [RC_W-1:0]                         r_out_col;
    logic [WIDTH_BIT-1:0]                    r_data;
    logic [OUT-1:0][OUT-1:0][WIDTH_BIT-1:0]  r_conv;

    logic                    w_last_tap;
    logic                    w_last_col;
    logic                    w_last_pix;
    logic [IX_W-1:0]         w_img_r;
    logic [IX_W-1:0]         w_img_c;
    logic signed [WIDTH_BIT-1:0] w_pix;
    logic signed [WIDTH_BIT-1:0] w_wt;
    logic signed [PW-1:0]    w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_shift;
    logic [WIDTH_BIT-1:0]    w_sat;

    assign w_last_tap = (r_kc == KR_W'(KER - 1)) && (r_kr == KR_W'(KER - 1)) &&
                        (r_ch == CH_W'(CH - 1));
    assign w_last_col = (r_col == RC_W'(OUT - 1));
    assign w_last_pix = w_last_col && (r_row == RC_W'(OUT - 1));

    assign w_img_r    = r_org_r + IX_W'(r_kr);
    assign w_img_c    = r_org_c + IX_W'(r_kc);
    assign w_pix      = $signed(inpMatrixI[r_ch][w_img_r][w_img_c]);
    assign w_wt       = $signed(kernel[r_ch][r_kr][r_kc]);
    assign w_prod     = PW'(w_pix) * PW'(w_wt);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_shift    = r_acc >>> SHIFT;

    // Clamp the shifted accumulator into the signed output range.
    always_comb begin
        w_sat = w_shift[WIDTH_BIT-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = SAT_MAX[WIDTH_BIT-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_sat = SAT_MIN[WIDTH_BIT-1:0];
        end
    end

    // State register.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a start arriving while done is still high is dropped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start && !r_done) w_next = S_LOAD;
            S_LOAD:  w_next = S_MAC;
            S_MAC:   if (w_last_tap) w_next = S_WRITE;
            S_WRITE: w_next = w_last_pix ? S_DONE : S_LOAD;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: window counters, accumulator and registered pixel outputs.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_row     <= '0;
            r_col     <= '0;
            r_org_r   <= '0;
            r_org_c   <= '0;
            r_kr      <= '0;
            r_kc      <= '0;
            r_ch      <= '0;
            r_acc     <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_out_row <= '0;
            r_out_col <= '0;
            r_data    <= '0;
            r_conv    <= '0;
        end else begin
            r_valid <= (r_state == S_WRITE);
            r_done  <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    r_row <= '0;
                    r_col <= '0;
                end
                S_LOAD: begin
                    r_acc   <= '0;
                    r_org_r <= IX_W'(r_row * STRIDE);
                    r_org_c <= IX_W'(r_col * STRIDE);
                    r_kr    <= '0;
                    r_kc    <= '0;
                    r_ch    <= '0;
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_kc == KR_W'(KER - 1)) begin
                        r_kc <= '0;
                        if (r_kr == KR_W'(KER - 1)) begin
                            r_kr <= '0;
                            r_ch <= r_ch + 1'b1;
                        end else begin
                            r_kr <= r_kr + 1'b1;
                        end
                    end else begin
                        r_kc <= r_kc + 1'b1;
                    end
                end
                S_WRITE: begin
                    r_data              <= w_sat;
                    r_out_row           <= r_row;
                    r_out_col           <= r_col;
                    r_conv[r_row][r_col] <= w_sat;
                    if (w_last_pix) begin
                        r_row <= '0;
                        r_col <= '0;
                    end else if (w_last_col) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state == S_LOAD) || (r_state == S_MAC) || (r_state == S_WRITE);
    assign done      = r_done;
    assign out_valid = r_valid;
    assign out_row   = r_out_row;
    assign out_col   = r_out_col;
    assign out_data  = r_data;
    assign convOut   = r_conv;

endmodule
